sseg_display_driver: RTL and testbench



---
 rtl/sseg_display_driver.sv | 246 ++++++++++++++++++++++++
 tb/tb_sseg_display_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_display_driver.sv
// sseg_display_driver
// Drives a 4-digit common-anode seven-segment display from a 16-bit value.
// In hex mode the four nibbles are shown directly. In decimal mode the value
// is converted to BCD by a sequential shift-and-add-3 engine, with
// leading-zero blanking and a dash pattern when the value exceeds 9999.
// The digits are scanned by a free-running refresh counter.
//
// Ports:
//   clk      - system clock, all state on the rising edge
//   rst      - asynchronous, active-high reset
//   data     - value to display, sampled continuously
//   hex_mode - 1 = four hex nibbles, 0 = unsigned decimal
//   segs     - active-low segments, segs[0]=a .. segs[6]=g, segs[7]=dp (off)
//   an       - active-low anodes, an[0] = rightmost digit
//   busy     - high while a capture/conversion/update is in flight
module sseg_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic        hex_mode,
    output logic [7:0]  segs,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t         state_r, state_nx_s;
    logic           stale_r;
    logic [16:0]    last_r;
    logic           mode_r;
    logic [15:0]    work_r;
    logic [19:0]    bcd_r;
    logic [3:0]     shift_cnt_r;
    logic [15:0]    digit_r;
    logic [3:0]     blank_r;
    logic           ovf_r;
    logic [CW-1:0]  refresh_r;
    logic [1:0]     idx_r;
    logic [7:0]     segs_r;
    logic [3:0]     an_r;
    logic           busy_r;

    logic           start_s;
    logic [19:0]    bcd_adj_s;
    logic [15:0]    upd_digits_s;
    logic [3:0]     upd_blank_s;
    logic           upd_ovf_s;
    logic [3:0]     sel_digit_s;
    logic           sel_blank_s;
    logic [3:0]     sel_an_s;

    // Add 3 to every BCD nibble that is 5 or more (the pre-shift correction).
    function automatic logic [19:0] add3_nibbles(input logic [19:0] v);
        logic [19:0] r;
        logic [3:0]  nib;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            nib = v[4*i +: 4];
            if (nib >= 4'd5) begin
                r[4*i +: 4] = nib + 4'd3;
            end else begin
                r[4*i +: 4] = nib;
            end
        end
        return r;
    endfunction

    // Active-low segment pattern for one hex digit; dp is always off.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // A new capture is needed after reset or when the input differs from the last capture.
    assign start_s   = stale_r || ({hex_mode, data} != last_r);
    assign bcd_adj_s = add3_nibbles(bcd_r);

    // Next-state logic for the capture / convert / update sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nx_s = hex_mode ? UPDATE : CONV;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CONV: begin
                if (shift_cnt_r == 4'd15) begin
                    state_nx_s = UPDATE;
                end else begin
                    state_nx_s = CONV;
                end
            end
            UPDATE:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Digit set, blank mask and overflow flag written atomically in UPDATE.
    always_comb begin
        upd_digits_s = work_r;
        upd_blank_s  = 4'b0000;
        upd_ovf_s    = 1'b0;
        if (mode_r) begin
            upd_digits_s = work_r;
        end else begin
            upd_digits_s = bcd_r[15:0];
            if (bcd_r[19:16] != 4'd0) begin
                upd_ovf_s = 1'b1;
            end else begin
                // Blank every digit above the most significant nonzero one; digit 0 always lit.
                upd_blank_s[3] = (bcd_r[15:12] == 4'd0);
                upd_blank_s[2] = (bcd_r[15:8]  == 8'd0);
                upd_blank_s[1] = (bcd_r[15:4]  == 12'd0);
                upd_blank_s[0] = 1'b0;
            end
        end
    end

    // Select the digit, blank bit and anode pattern of the current scan slot.
    always_comb begin
        sel_digit_s = digit_r[3:0];
        sel_blank_s = blank_r[0];
        sel_an_s    = 4'b1110;
        case (idx_r)
            2'd0: begin sel_digit_s = digit_r[3:0];   sel_blank_s = blank_r[0]; sel_an_s = 4'b1110; end
            2'd1: begin sel_digit_s = digit_r[7:4];   sel_blank_s = blank_r[1]; sel_an_s = 4'b1101; end
            2'd2: begin sel_digit_s = digit_r[11:8];  sel_blank_s = blank_r[2]; sel_an_s = 4'b1011; end
            2'd3: begin sel_digit_s = digit_r[15:12]; sel_blank_s = blank_r[3]; sel_an_s = 4'b0111; end
            default: begin sel_digit_s = 4'd0; sel_blank_s = 1'b1; sel_an_s = 4'b1111; end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Capture, double-dabble datapath and display digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_r     <= 1'b1;
            last_r      <= 17'd0;
            mode_r      <= 1'b0;
            work_r      <= 16'd0;
            bcd_r       <= 20'd0;
            shift_cnt_r <= 4'd0;
            digit_r     <= 16'd0;
            blank_r     <= 4'b1110;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        last_r      <= {hex_mode, data};
                        mode_r      <= hex_mode;
                        work_r      <= data;
                        stale_r     <= 1'b0;
                        bcd_r       <= 20'd0;
                        shift_cnt_r <= 4'd0;
                    end
                end
                CONV: begin
                    // Correct first, then shift the next data MSB into the BCD LSB.
                    bcd_r       <= {bcd_adj_s[18:0], work_r[15]};
                    work_r      <= {work_r[14:0], 1'b0};
                    shift_cnt_r <= shift_cnt_r + 4'd1;
                end
                UPDATE: begin
                    digit_r <= upd_digits_s;
                    blank_r <= upd_blank_s;
                    ovf_r   <= upd_ovf_s;
                end
                default: begin
                    stale_r <= 1'b1;
                end
            endcase
        end
    end

    // Free-running refresh counter and scan digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_r <= '0;
            idx_r     <= 2'd0;
        end else if (refresh_r == REFRESH_MAX) begin
            refresh_r <= '0;
            idx_r     <= idx_r + 2'd1;
        end else begin
            refresh_r <= refresh_r + CW'(1);
        end
    end

    // Registered display outputs and busy flag (busy spans capture through update).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r   <= 4'hF;
            segs_r <= 8'hFF;
            busy_r <= 1'b0;
        end else begin
            an_r   <= sel_blank_s ? 4'hF : sel_an_s;
            segs_r <= ovf_r ? 8'hBF : seg_decode(sel_digit_s);
            busy_r <= (state_r != IDLE) || start_s;
        end
    end

    assign an   = an_r;
    assign segs = segs_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_sseg_display_driver.sv
// Directed testbench for sseg_display_driver with REFRESH_DIV = 4.
module tb_sseg_display_driver;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        hex_mode;
    logic [7:0]  segs;
    logic [3:0]  an;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected segs per slot (0..3) for the mid-change sequence: 000A hex, 1234, 5678.
    logic [7:0] mix_tbl [0:2][0:3] = '{
        '{8'h88, 8'hC0, 8'hC0, 8'hC0},
        '{8'h99, 8'hB0, 8'hA4, 8'hF9},
        '{8'h80, 8'hF8, 8'h82, 8'h92}
    };

    sseg_display_driver #(.REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .hex_mode (hex_mode),
        .segs     (segs),
        .an       (an),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for busy to rise, then count the samples it stays high.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b1) break;
            @(negedge clk);
        end
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Align to the start of the slot-0 window, then check 4 slots x 4 cycles.
    task automatic scan(input string tag, input logic [15:0] ean, input logic [31:0] esegs);
        logic [3:0] prev;
        logic [3:0] ea;
        logic       found;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an === ean[3:0] && prev !== ean[3:0]) begin
                found = 1'b1;
                break;
            end
            prev = an;
        end
        chk($sformatf("%s sync", tag), {31'd0, found}, 32'd1);
        if (found) begin
            for (int s = 0; s < 4; s++) begin
                ea = ean[4*s +: 4];
                for (int k = 0; k < RD; k++) begin
                    if (s != 0 || k != 0) @(negedge clk);
                    chk($sformatf("%s an slot%0d", tag, s), {28'd0, an}, {28'd0, ea});
                    if (ea != 4'hF)
                        chk($sformatf("%s segs slot%0d", tag, s), {24'd0, segs}, {24'd0, esegs[8*s +: 8]});
                end
            end
        end
    endtask

    initial begin
        int n;
        int phase;
        int seen1234;
        int slot;
        int set_id;

        // Reset with decimal 1234 on the inputs.
        rst = 1'b1; hex_mode = 1'b0; data = 16'd1234;
        repeat (3) @(negedge clk);
        chk("reset an", {28'd0, an}, 32'h0000000F);
        chk("reset segs", {24'd0, segs}, 32'h000000FF);
        chk("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("busy rise after reset", {31'd0, busy}, 32'd1);
        count_busy(n);
        chk("busy len 1234", n, 32'd18);
        scan("d1234", 16'h7BDE, 32'hF9A4B099);

        // Leading-zero blanking.
        data = 16'd7;
        count_busy(n);
        chk("busy len 7", n, 32'd18);
        scan("d7", 16'hFFFE, 32'h000000F8);
        data = 16'd0;
        count_busy(n);
        scan("d0", 16'hFFFE, 32'h000000C0);

        // Overflow above 9999 and the largest in-range value.
        data = 16'd12345;
        count_busy(n);
        chk("busy len 12345", n, 32'd18);
        scan("d12345", 16'h7BDE, 32'hBFBFBFBF);
        data = 16'd9999;
        count_busy(n);
        scan("d9999", 16'h7BDE, 32'h90909090);

        // Hex mode: single-cycle update, no blanking.
        hex_mode = 1'b1; data = 16'hBEEF;
        count_busy(n);
        chk("busy len BEEF", n, 32'd2);
        scan("hBEEF", 16'h7BDE, 32'h8386868E);
        data = 16'h000A;
        count_busy(n);
        chk("busy len 000A", n, 32'd2);
        scan("h000A", 16'h7BDE, 32'hC0C0C088);

        // Input change mid-conversion: 000A -> 1234 -> 5678, never mixed or out of order.
        hex_mode = 1'b0; data = 16'd1234;
        phase = 0; seen1234 = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 5) data = 16'd5678;
            case (an)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b0111: slot = 3;
                default: slot = -1;
            endcase
            set_id = 3;
            if (slot >= 0) begin
                for (int j = 0; j < 3; j++)
                    if (segs === mix_tbl[j][slot]) set_id = j;
            end
            chk($sformatf("mix seq sample%0d an=%h segs=%h", i, an, segs),
                {31'd0, (set_id >= phase) && (set_id < 3)}, 32'd1);
            if (set_id < 3 && set_id > phase) phase = set_id;
            if (set_id == 1) seen1234++;
        end
        chk("mix final phase", phase, 32'd2);
        chk("mix 1234 shown", {31'd0, seen1234 >= 16}, 32'd1);

        // Reset in the middle of a conversion.
        data = 16'd4321;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset an", {28'd0, an}, 32'h0000000F);
        chk("midreset segs", {24'd0, segs}, 32'h000000FF);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("busy rise after midreset", {31'd0, busy}, 32'd1);
        count_busy(n);
        chk("busy len 4321", n, 32'd18);
        scan("d4321", 16'h7BDE, 32'h99B0A4F9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
